// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for a 32-entry register file: zero-init sweep of r1..r(2**AW-1),
// then round-robin sharing of the single write port between two valid/ready requesters.
module regfile_wr_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_req,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          rf_wr,
    output logic          rf_en,
    output logic [AW-1:0] rf_sel,
    output logic [DW-1:0] rf_data,
    output logic          init_done,
    output logic [15:0]   wr_count
);

    localparam logic [0:0]    ST_INIT = 1'b0;
    localparam logic [0:0]    ST_RUN  = 1'b1;
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [0:0]    state_reg;
    logic [AW-1:0] init_addr_reg;
    logic          last_grant_reg;

    logic          grant;
    logic          fire;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;

    // With both valid, the requester that did not win last gets the port.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_reg;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        fire       = (state_reg == ST_RUN) && !clear_req && (req0_valid || req1_valid);
        req0_ready = fire && !grant;
        req1_ready = fire && grant;
        win_addr   = grant ? req1_addr : req0_addr;
        win_data   = grant ? req1_data : req0_data;
    end

    assign init_done = (state_reg == ST_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_INIT;
            init_addr_reg  <= ADDR_ONE;
            last_grant_reg <= 1'b1;
            rf_wr          <= 1'b0;
            rf_en          <= 1'b0;
            rf_sel         <= '0;
            rf_data        <= '0;
            wr_count       <= '0;
        end else begin
            rf_en <= 1'b1;
            if (clear_req) begin
                state_reg     <= ST_INIT;
                init_addr_reg <= ADDR_ONE;
                rf_wr         <= 1'b0;
                wr_count      <= '0;
            end else if (state_reg == ST_INIT) begin
                // init_addr wraps to 0 after the last entry; that marks the sweep as finished.
                if (init_addr_reg != '0) begin
                    rf_wr         <= 1'b1;
                    rf_sel        <= init_addr_reg;
                    rf_data       <= '0;
                    init_addr_reg <= init_addr_reg + ADDR_ONE;
                end else begin
                    rf_wr     <= 1'b0;
                    state_reg <= ST_RUN;
                end
            end else if (fire) begin
                last_grant_reg <= grant;
                // r0 is hardwired zero: accept the transfer but never write it.
                rf_wr <= (win_addr != '0);
                if (win_addr != '0) begin
                    rf_sel  <= win_addr;
                    rf_data <= win_data;
                    if (wr_count != 16'hFFFF) begin
                        wr_count <= wr_count + 16'd1;
                    end
                end
            end else begin
                rf_wr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: init sweep, single/conflicting requests,
// r0 writes, clear_req restart and asynchronous reset mid-sweep.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_req;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rf_wr, rf_en, init_done;
    logic [4:0]  rf_sel;
    logic [31:0] rf_data;
    logic [15:0] wr_count;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_wr(rf_wr), .rf_en(rf_en), .rf_sel(rf_sel), .rf_data(rf_data),
        .init_done(init_done), .wr_count(wr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] d0, d1;
        int g;
        rst = 1'b0; clear_req = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

        #3;
        chk("rst_rf_wr", 32'(rf_wr), 0);
        chk("rst_rf_en", 32'(rf_en), 0);
        chk("rst_rf_sel", 32'(rf_sel), 0);
        chk("rst_rf_data", rf_data, 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_wr_count", 32'(wr_count), 0);

        @(negedge clk);
        rst = 1'b1;

        // Sweep r1..r31 after reset release
        for (int k = 1; k <= 31; k++) begin
            step();
            $display("sweep cycle %0d: rf_wr=%0b rf_sel=%0d", k, rf_wr, rf_sel);
            chk("sweep_wr", 32'(rf_wr), 1);
            chk("sweep_sel", 32'(rf_sel), 32'(k));
            chk("sweep_data", rf_data, 0);
            chk("sweep_ready", 32'({req0_ready, req1_ready}), 0);
            chk("sweep_en", 32'(rf_en), 1);
            chk("sweep_done", 32'(init_done), 0);
        end
        step();
        chk("run_init_done", 32'(init_done), 1);
        chk("run_idle_wr", 32'(rf_wr), 0);

        // Single request from req0
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        chk("single_ready0", 32'(req0_ready), 1);
        chk("single_ready1", 32'(req1_ready), 0);
        step();
        req0_valid = 1'b0;
        $display("single req0: rf_wr=%0b rf_sel=%0d rf_data=%h wr_count=%0d", rf_wr, rf_sel, rf_data, wr_count);
        chk("single_wr", 32'(rf_wr), 1);
        chk("single_sel", 32'(rf_sel), 5);
        chk("single_data", rf_data, 32'hDEADBEEF);
        chk("single_count", 32'(wr_count), 1);
        step();
        chk("single_wr_drop", 32'(rf_wr), 0);

        // req1 writes r0: accepted, but no write and no count
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
        #1;
        chk("r0_ready1", 32'(req1_ready), 1);
        step();
        req1_valid = 1'b0;
        $display("r0 write: rf_wr=%0b wr_count=%0d", rf_wr, wr_count);
        chk("r0_wr", 32'(rf_wr), 0);
        chk("r0_count", 32'(wr_count), 1);

        // Conflict on r3 for 4 cycles: req0 wins first (last grant was req1)
        d0 = 32'hA000_0000; d1 = 32'hB000_0000;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = d0;
        req1_valid = 1'b1; req1_addr = 5'd3; req1_data = d1;
        for (int i = 0; i < 4; i++) begin
            g = i % 2;
            #1;
            chk("conf_ready0", 32'(req0_ready), 32'(g == 0));
            chk("conf_ready1", 32'(req1_ready), 32'(g == 1));
            step();
            $display("conflict %0d: grant=%0d rf_wr=%0b rf_sel=%0d rf_data=%h", i, g, rf_wr, rf_sel, rf_data);
            chk("conf_wr", 32'(rf_wr), 1);
            chk("conf_sel", 32'(rf_sel), 3);
            chk("conf_data", rf_data, (g == 0) ? d0 : d1);
            if (g == 0) begin
                d0 = d0 + 32'd1; req0_data = d0;
            end else begin
                d1 = d1 + 32'd1; req1_data = d1;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("conf_last_data", rf_data, 32'hB000_0001);
        chk("conf_count", 32'(wr_count), 5);

        // clear_req while req0 waits: sweep reruns, then req0 goes through
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h55;
        clear_req = 1'b1;
        #1;
        chk("clr_ready0", 32'(req0_ready), 0);
        step();
        clear_req = 1'b0;
        chk("clr_count", 32'(wr_count), 0);
        chk("clr_done", 32'(init_done), 0);
        for (int k = 1; k <= 31; k++) begin
            step();
            chk("clr_sweep_sel", 32'(rf_sel), 32'(k));
            chk("clr_sweep_wr", 32'(rf_wr), 1);
            chk("clr_sweep_ready", 32'(req0_ready), 0);
        end
        step();
        chk("clr_run_done", 32'(init_done), 1);
        chk("clr_run_ready0", 32'(req0_ready), 1);
        step();
        req0_valid = 1'b0;
        $display("after clear: rf_wr=%0b rf_sel=%0d rf_data=%h wr_count=%0d", rf_wr, rf_sel, rf_data, wr_count);
        chk("clr_wr", 32'(rf_wr), 1);
        chk("clr_sel", 32'(rf_sel), 7);
        chk("clr_data", rf_data, 32'h55);
        chk("clr_count_after", 32'(wr_count), 1);

        // Reset mid-sweep at rf_sel=12
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int k = 1; k <= 12; k++) step();
        chk("mid_sel", 32'(rf_sel), 12);
        rst = 1'b0;
        #1;
        $display("mid-sweep reset: rf_wr=%0b rf_en=%0b init_done=%0b", rf_wr, rf_en, init_done);
        chk("mid_rst_wr", 32'(rf_wr), 0);
        chk("mid_rst_en", 32'(rf_en), 0);
        chk("mid_rst_done", 32'(init_done), 0);
        chk("mid_rst_sel", 32'(rf_sel), 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("restart_sel", 32'(rf_sel), 1);
        chk("restart_wr", 32'(rf_wr), 1);
        step();
        chk("restart_sel2", 32'(rf_sel), 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback requesters, e.g. the ALU (req0) and the load unit (req1).
- Valid/ready handshake per requester; round-robin grant on conflict.
- Runs a zero-initialisation sweep of r1..r31 after reset and on demand.
- Drives the register file's write-side inputs (Ip1, sel_i1, WR, EN) from registered outputs.

Parameters:
DW, 32, data width of the register file
AW, 5, register address width (2**AW entries)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
clear_req  input  1  one-cycle pulse: restart the init sweep
req0_valid  input  1  requester 0 has a write pending
req0_addr  input  AW  requester 0 destination register
req0_data  input  DW  requester 0 write data
req0_ready  output  1  requester 0 transfer accepted this cycle
req1_valid  input  1  requester 1 has a write pending
req1_addr  input  AW  requester 1 destination register
req1_data  input  DW  requester 1 write data
req1_ready  output  1  requester 1 transfer accepted this cycle
rf_wr  output  1  to register file WR
rf_en  output  1  to register file EN
rf_sel  output  AW  to register file sel_i1
rf_data  output  DW  to register file Ip1
init_done  output  1  high while in RUN
wr_count  output  16  committed requester writes, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - state=INIT, init_addr=1, last_grant=1 (so req0 wins the first conflict).
  - rf_wr=0, rf_en=0, rf_sel=0, rf_data=0, init_done=0, wr_count=0.
  - Ready outputs are 0.
- After reset release, rf_en=1 from the first posedge onward.
- rf_wr, rf_sel and rf_data are registered on posedge. The register file captures on the following negedge of the same cycle.
- INIT state:
  - Each cycle: rf_wr=1, rf_sel=init_addr, rf_data=0, init_addr+=1.
  - After the cycle with init_addr=31, go to RUN.
  - The sweep takes exactly 31 cycles. r0 is never written.
  - Both ready outputs are 0 throughout.
- RUN state:
  - reqN_ready is combinational: RUN & ~clear_req & grant==N. A transfer is valid&ready in the same cycle.
  - Grant with only one valid: that requester.
  - Grant with both valid: the requester that is not last_grant. last_grant updates on every transfer.
  - Grant with neither valid: none; last_grant is held.
  - Latency: transfer at posedge N gives rf_wr=1 with that addr/data during cycle N+1, for one cycle only. rf_wr=0 in cycles with no transfer.
  - Back-to-back transfers every cycle are supported (100% port throughput).
  - A transfer with addr=0 is accepted (ready=1) but rf_wr stays 0 and wr_count does not increment. r0 stays zero.
  - The loser of a conflict keeps valid/addr/data stable and is granted the next cycle. For the same address, the loser's data lands last.
- Held requests: requesters must hold valid, addr and data until ready. The arbiter never drops an accepted transfer.
- clear_req in RUN:
  - Ready outputs are 0 in that cycle (clear wins over any request). The next state is INIT with init_addr=1.
  - wr_count clears to 0.
  - A write accepted in the previous cycle still completes (it is already registered on the rf outputs).
- clear_req during INIT restarts the sweep at init_addr=1.
- wr_count increments by 1 per committed non-r0 requester write and saturates at 16'hFFFF. Init writes are not counted.
- Reset asserted mid-sweep or mid-transfer:
  - Outputs clear immediately.
  - Any in-flight write is abandoned.
  - The full sweep reruns after release.

Test Plan:
- Release reset, no requests -> rf_wr=1 for 31 consecutive cycles with rf_sel 1..31 and rf_data=0; init_done rises on cycle 32; both readies 0 during the sweep.
- RUN, req0 valid addr=5 data=32'hDEADBEEF alone -> req0_ready=1 same cycle; next cycle rf_wr=1, rf_sel=5, rf_data=DEADBEEF; wr_count=1.
- RUN, both valid every cycle for 4 cycles (req0 addr 3, req1 addr 3, distinct data) -> grants alternate 0,1,0,1 starting with req0; rf_wr high 4 consecutive cycles; the last write to r3 is req1's data.
- RUN, req1 valid addr=0 data=32'h1234 -> req1_ready=1; rf_wr stays 0; wr_count unchanged.
- RUN, clear_req pulsed while req0 valid -> req0_ready=0 that cycle; 31-cycle sweep follows; wr_count=0; req0 is accepted in the first RUN cycle after the sweep.
- Drive rst low mid-sweep at init_addr=12 -> rf_wr, init_done and rf_en go 0 immediately; after release the sweep restarts at rf_sel=1.
